// File: rtl/timer_responder_if.sv
// Data-bus port between the CPU load/store unit and the timer responder.
// Single-cycle request, registered one-cycle acknowledge.
interface timer_responder_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/timer_responder.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT registers, 4-state count FSM,
// maskable interrupt. Answers every request with a registered ack one cycle later.
module timer_responder (
    input  logic               clk,
    input  logic               reset,
    timer_responder_if.slave   bus,
    output logic               irq
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_e;

    state_e      state_q, state_d;
    logic        en_q, en_d;
    logic [1:0]  mode_q, mode_d;
    logic        im_q, im_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        pending_q, pending_d;
    logic        ack_q, ack_d;
    logic [31:0] rdata_q, rdata_d;
    logic        wr_ctrl, wr_preset, pend_set;

    assign wr_ctrl   = bus.req && bus.we && (bus.addr[3:2] == 2'b00);
    assign wr_preset = bus.req && bus.we && (bus.addr[3:2] == 2'b01);

    always_comb begin
        state_d   = state_q;
        en_d      = en_q;
        mode_d    = mode_q;
        im_d      = im_q;
        preset_d  = preset_q;
        count_d   = count_q;
        pending_d = pending_q;
        pend_set  = 1'b0;
        ack_d     = bus.req;
        rdata_d   = '0;

        unique case (state_q)
            S_IDLE: if (en_q) state_d = S_LOAD;
            S_LOAD: begin
                count_d = preset_q;
                state_d = S_CNT;
            end
            S_CNT: begin
                if (!en_q) begin
                    state_d = S_IDLE;
                end else if (count_q <= 32'd1) begin
                    // PRESET=0 lands here too, so it behaves like PRESET=1
                    count_d  = '0;
                    pend_set = 1'b1;
                    state_d  = S_INT;
                end else begin
                    count_d = count_q - 32'd1;
                end
            end
            S_INT: begin
                if (mode_q == 2'b01) begin
                    state_d = S_LOAD;
                end else begin
                    en_d    = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Software stores come after the FSM so a CTRL write beats the INT EN-clear
        if (wr_ctrl) {im_d, mode_d, en_d} = bus.wdata[3:0];
        if (wr_preset) preset_d = bus.wdata;
        if (wr_ctrl || wr_preset) pending_d = 1'b0;
        if (pend_set) pending_d = 1'b1;

        if (bus.req && !bus.we) begin
            unique case (bus.addr[3:2])
                2'b00:   rdata_d = {28'd0, im_q, mode_q, en_q};
                2'b01:   rdata_d = preset_q;
                2'b10:   rdata_d = count_q;
                default: rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            en_q      <= 1'b0;
            mode_q    <= 2'b00;
            im_q      <= 1'b0;
            preset_q  <= '0;
            count_q   <= '0;
            pending_q <= 1'b0;
            ack_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            mode_q    <= mode_d;
            im_q      <= im_d;
            preset_q  <= preset_d;
            count_q   <= count_d;
            pending_q <= pending_d;
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
        end
    end

    assign bus.ack   = ack_q;
    assign bus.rdata = rdata_q;
    assign irq       = pending_q & im_q;
endmodule

// File: tb/tb_timer_responder.sv
// Directed bench for timer_responder: every task step is one clock, inputs driven
// and outputs sampled on the falling edge.
module tb_timer_responder;
    localparam logic [31:0] A_CTRL = 32'h0, A_PRE = 32'h4, A_CNT = 32'h8, A_RSV = 32'hC;

    logic clk = 1'b0;
    logic reset;
    logic irq;
    int   n_chk = 0;
    int   n_pass = 0;

    timer_responder_if bus ();

    timer_responder dut (.clk(clk), .reset(reset), .bus(bus), .irq(irq));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    endtask

    task automatic cyc(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        bus.req   = r;
        bus.we    = w;
        bus.addr  = a;
        bus.wdata = d;
        @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        cyc(1'b1, 1'b1, a, d);
        chk("wr_ack", {31'd0, bus.ack}, 32'd1);
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        cyc(1'b1, 1'b0, a, 32'd0);
        chk({tag, "_ack"}, {31'd0, bus.ack}, 32'd1);
        chk(tag, bus.rdata, exp);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 1'b0, 32'd0, 32'd0);
            chk("idle_ack", {31'd0, bus.ack}, 32'd0);
            chk("idle_rdata", bus.rdata, 32'd0);
        end
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        chk(tag, {31'd0, irq}, {31'd0, exp});
    endtask

    initial begin
        reset = 1'b0;
        bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ack", {31'd0, bus.ack}, 32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        chk_irq("rst_irq", 1'b0);
        reset = 1'b1;

        // Reset values
        rd("rst_ctrl", A_CTRL, 32'h0);
        rd("rst_pre", A_PRE, 32'h0);
        rd("rst_cnt", A_CNT, 32'h0);
        idle(1);
        chk_irq("rst_irq2", 1'b0);

        // One-shot, PRESET=5, CTRL=0x9 written at edge E
        wr(A_PRE, 32'd5);
        wr(A_CTRL, 32'h9);
        idle(2);
        for (int k = 0; k < 5; k++) begin
            rd("os_cnt", A_CNT, 32'(5 - k));
            chk_irq("os_irq", k == 4);
        end
        idle(1);
        rd("os_ctrl", A_CTRL, 32'h8);
        rd("os_cnt0", A_CNT, 32'h0);
        chk_irq("os_irq_hold", 1'b1);
        wr(A_CTRL, 32'h8);
        chk_irq("os_irq_clr", 1'b0);

        // PRESET=0 behaves like 1: INT three edges after enable
        wr(A_PRE, 32'd0);
        wr(A_CTRL, 32'h9);
        idle(2);
        chk_irq("p0_irq_early", 1'b0);
        idle(1);
        chk_irq("p0_irq", 1'b1);
        wr(A_CTRL, 32'h8);

        // Store CTRL=0x1 in the INT cycle: software wins, timer restarts
        wr(A_PRE, 32'd2);
        wr(A_CTRL, 32'h9);
        idle(4);
        chk_irq("col_int", 1'b1);
        wr(A_CTRL, 32'h1);
        rd("col_ctrl", A_CTRL, 32'h1);
        idle(1);
        rd("col_restart", A_CNT, 32'd2);
        wr(A_CTRL, 32'h0);
        idle(3);

        // PRESET store on the same edge pending sets: set wins
        wr(A_PRE, 32'd2);
        wr(A_CTRL, 32'h9);
        idle(3);
        wr(A_PRE, 32'd7);
        chk_irq("col_setwins", 1'b1);
        idle(2);
        wr(A_CTRL, 32'h8);

        // Auto-reload, PRESET=3, CTRL=0xB at E
        wr(A_PRE, 32'd3);
        wr(A_CTRL, 32'hB);
        idle(2);
        rd("ar_c3", A_CNT, 32'd3);
        rd("ar_c2", A_CNT, 32'd2);
        chk_irq("ar_irq_pre", 1'b0);
        rd("ar_c1", A_CNT, 32'd1);
        chk_irq("ar_irq1", 1'b1);
        wr(A_PRE, 32'd3);
        chk_irq("ar_irq_clr", 1'b0);
        rd("ar_c0", A_CNT, 32'd0);
        rd("ar_r3", A_CNT, 32'd3);
        rd("ar_r2", A_CNT, 32'd2);
        chk_irq("ar_irq_pre2", 1'b0);
        rd("ar_r1", A_CNT, 32'd1);
        chk_irq("ar_irq2", 1'b1);

        // IM=0: irq masked while the timer keeps cycling
        wr(A_CTRL, 32'h3);
        for (int k = 0; k < 7; k++) begin
            idle(1);
            chk_irq("ar_masked", 1'b0);
        end
        rd("ar_m_cnt", A_CNT, 32'd2);
        wr(A_CTRL, 32'hB);
        chk_irq("ar_unmask_setwins", 1'b1);
        wr(A_CTRL, 32'h0);
        chk_irq("ar_off_irq", 1'b0);
        idle(2);
        rd("ar_stop1", A_CNT, 32'd3);
        rd("ar_stop2", A_CNT, 32'd3);

        // Access rules
        wr(A_CNT, 32'hFFFF_FFFF);
        rd("acc_cnt", A_CNT, 32'd3);
        wr(A_RSV, 32'hFFFF_FFFF);
        rd("acc_rsv", A_RSV, 32'h0);
        wr(A_CTRL, 32'hFFFF_FFF0);
        rd("acc_ctrl", A_CTRL, 32'h0);
        rd("acc_hibits", 32'h1000_0004, 32'd3);

        // Back-to-back loads
        wr(A_PRE, 32'h1234);
        for (int k = 0; k < 4; k++) rd("b2b", A_PRE, 32'h1234);
        idle(1);

        // Reset mid-count with a same-cycle store
        wr(A_PRE, 32'd100);
        wr(A_CTRL, 32'h9);
        idle(2);
        rd("mid_cnt", A_CNT, 32'd100);
        reset = 1'b0;
        cyc(1'b1, 1'b1, A_CTRL, 32'h1);
        chk("mid_rst_ack", {31'd0, bus.ack}, 32'd0);
        chk("mid_rst_rdata", bus.rdata, 32'd0);
        chk_irq("mid_rst_irq", 1'b0);
        reset = 1'b1;
        rd("mid_cnt0", A_CNT, 32'd0);
        rd("mid_ctrl0", A_CTRL, 32'd0);
        rd("mid_pre0", A_PRE, 32'd0);
        idle(3);
        rd("mid_idle_cnt", A_CNT, 32'd0);
        chk_irq("mid_irq", 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/timer_responder.md
# timer_responder

Memory-mapped countdown timer acting as a bus responder to the CPU data-memory port. The CPU issues load/store requests and the block answers with a registered one-cycle acknowledge. It exposes three word registers (CTRL, PRESET, COUNT), runs a 4-state countdown FSM, and raises a maskable interrupt line. It sits beside DM on the CPU data bus; address decode of the block's window is done outside it.

## Interface
- No parameters; the register offset decode uses addr[3:2] only.
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  one clock; reset is synchronous and active-low
- req  input  1  access request, one transfer per cycle it is high (block already selected)
- we  input  1  1 = store, 0 = load; sampled with req
- addr  input  32  byte address; addr[3:2] selects the register, all other bits ignored
- wdata  input  32  store data; sampled with req & we
- ack  output  1  response strobe, high exactly one cycle after each accepted req
- rdata  output  32  load data, valid while ack is high, 0 otherwise
- irq  output  1  interrupt = pending & CTRL.IM

## Operation
- Register map (addr[3:2]):
  - 00 CTRL, read/write.
    - [0] EN: enable.
    - [2:1] MODE: 00 one-shot, 01 auto-reload, 1x treated as one-shot.
    - [3] IM: interrupt mask.
    - [31:4] read as 0, writes to them are discarded.
  - 01 PRESET, 32-bit read/write.
  - 10 COUNT, read-only; writes are ignored.
  - 11 reserved: reads 0, writes ignored.
- Reset (reset==0 at an edge):
  - CTRL, PRESET and COUNT go to 0.
  - pending goes to 0, FSM goes to IDLE.
  - ack, rdata and irq go to 0.
  - Reset overrides any same-cycle req.
  - Reset mid-count abandons the count; no ack is produced for a req in the reset cycle.
- Bus:
  - On each edge with req=1, rdata is captured from the register values before that edge's updates, and ack is set to 1.
  - On an edge with req=0, ack and rdata are set to 0.
  - Back-to-back requests are acknowledged every cycle.
  - A store to CTRL or to PRESET clears pending.
- FSM:
  - IDLE:
    - COUNT holds.
    - If EN=1, go to LOAD.
  - LOAD:
    - COUNT ← PRESET, go to CNT.
  - CNT:
    - If EN=0, go to IDLE; COUNT holds.
    - Else if COUNT ≤ 1: COUNT ← 0, pending ← 1, go to INT.
    - Else COUNT ← COUNT − 1.
  - INT (one cycle):
    - MODE=01: go to LOAD.
    - Otherwise: EN ← 0, go to IDLE.
- Simultaneous events:
  - A software store to CTRL in the same cycle that INT clears EN: the software value wins.
  - A store to CTRL/PRESET in the same cycle pending would be set (CNT→INT): pending ends at 1 (set wins over clear).
  - A PRESET write during CNT does not change the running count; it takes effect at the next LOAD.
  - Clearing EN during INT in auto-reload mode: the FSM still goes to LOAD, then to IDLE from CNT.
- Arithmetic:
  - COUNT is unsigned 32-bit.
  - PRESET=0 behaves like PRESET=1: one CNT cycle, then INT.
  - No wrap-around below 0.

## Timing
- Store accepted at edge E: register updated at E; ack and rdata visible after E, cleared at E+1 unless another req.
- Load latency is 1 cycle: rdata is valid in the cycle after the req cycle.
- Sequence for CTRL.EN written 1 at edge E with PRESET=P ≥ 1:
  - LOAD after E+1.
  - COUNT=P after E+2.
  - COUNT=1 after E+P+1.
  - INT, COUNT=0 and pending=1 after E+P+2.
- Auto-reload period is P+2 cycles (CNT P, INT 1, LOAD 1); for PRESET=0 the period is 3 cycles.
- irq is the combinational AND of the pending register and the IM register; it has no extra latency.

## Test plan
- Reset sequence:
  - Stimulus: hold reset=0 for 2 cycles, release, then load CTRL, PRESET and COUNT.
  - Required: each load returns 0x0; ack is high only in the cycle after each req; irq=0 throughout.
- One-shot:
  - Stimulus: store PRESET=5, then store CTRL=0x9 (EN, IM) at edge E.
  - Required: COUNT reads 5,4,3,2,1; irq rises after E+7; CTRL reads 0x8 afterwards; irq stays high until a store to CTRL.
- Auto-reload:
  - Stimulus: PRESET=3, CTRL=0xB.
  - Required: pending is set every 5 cycles; COUNT sequence 3,2,1,0 repeats.
  - With IM=0 (CTRL=0x3): irq stays 0 while pending still sets.
- Access rules:
  - Stimulus: store 0xFFFF_FFFF to COUNT and to offset 0xC; store 0xFFFF_FFF0 to CTRL.
  - Required: COUNT unchanged; offset 0xC reads 0; CTRL reads 0x0.
- Collision cases:
  - Stimulus: store CTRL=0x1 in the INT cycle of a one-shot run.
  - Required: CTRL ends 0x1 and the timer restarts.
  - Stimulus: assert reset=0 mid-CNT with COUNT=100.
  - Required: after the edge, COUNT=0, FSM in IDLE, irq=0, ack=0.
- Back-to-back requests:
  - Stimulus: 4 consecutive load reqs to PRESET=0x1234.
  - Required: ack is high for 4 consecutive cycles, each with rdata=0x1234.
